// File: rtl/reg_mask_encoder.sv
`default_nettype none
// ============================================================================
// Module   : reg_mask_encoder
// Purpose  : Captures a 16-bit register-select mask and emits the index of
//            each selected register, lowest first, one per accepted Ack.
//            A Done pulse marks the end of every accepted Load, including a
//            Load whose effective mask is empty.
// Ports    : clk        - system clock, rising edge
//            rst        - synchronous active-high reset
//            Load       - capture Mask (honoured only while Ready)
//            Mask[15:0] - register-select vector, bit i selects register i
//            Ack        - consumer accepts RegId (honoured only while Valid)
//            Ready      - idle and able to accept Load
//            Valid      - RegId holds a pending register index
//            RegId[3:0] - lowest set bit index of the pending mask
//            Remaining  - population count of the pending mask (0..16)
//            Done       - one-cycle pulse when a loaded mask is drained
// Options  : MASK_ENC_SKIP_R0_EN - when defined, bit 0 of Mask is ignored so
//            register 0 is never emitted nor counted.
// Revision : 1.0 - initial release
// ============================================================================
module reg_mask_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic        Load,
    input  logic [15:0] Mask,
    input  logic        Ack,
    output logic        Ready,
    output logic        Valid,
    output logic [3:0]  RegId,
    output logic [4:0]  Remaining,
    output logic        Done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EMIT = 1'b1;

    logic [0:0]  r_state;
    logic [15:0] r_mask;
    logic [4:0]  r_remaining;
    logic        r_done;

    logic [0:0]  w_state_nxt;
    logic [15:0] w_mask_nxt;
    logic [4:0]  w_remaining_nxt;
    logic        w_done_nxt;

    logic [15:0] w_eff_mask;
    logic [3:0]  w_low_idx;
    logic [15:0] w_low_onehot;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(v[i]);
        end
        return cnt;
    endfunction

`ifdef MASK_ENC_SKIP_R0_EN
    assign w_eff_mask = {Mask[15:1], 1'b0};
`else
    assign w_eff_mask = Mask;
`endif

    // Scan from the top down so the last hit, i.e. the lowest set bit, wins.
    always_comb begin
        w_low_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (r_mask[i]) begin
                w_low_idx = 4'(i);
            end
        end
    end

    assign w_low_onehot = 16'd1 << w_low_idx;

    always_comb begin
        w_state_nxt     = r_state;
        w_mask_nxt      = r_mask;
        w_remaining_nxt = r_remaining;
        w_done_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (Load) begin
                    if (w_eff_mask == 16'd0) begin
                        // Empty request still completes, with no emission.
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = S_EMIT;
                        w_mask_nxt      = w_eff_mask;
                        w_remaining_nxt = popcount16(w_eff_mask);
                    end
                end
            end
            S_EMIT: begin
                if (Ack) begin
                    w_mask_nxt      = r_mask & ~w_low_onehot;
                    w_remaining_nxt = r_remaining - 5'd1;
                    if (r_remaining == 5'd1) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_mask_nxt      = 16'd0;
                w_remaining_nxt = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mask      <= 16'd0;
            r_remaining <= 5'd0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mask      <= w_mask_nxt;
            r_remaining <= w_remaining_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign Ready     = (r_state == S_IDLE);
    assign Valid     = (r_state == S_EMIT);
    assign RegId     = (r_state == S_EMIT) ? w_low_idx : 4'd0;
    assign Remaining = r_remaining;
    assign Done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_mask_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_mask_encoder
// Purpose  : Self-checking bench for reg_mask_encoder. A reference model
//            holds the pending registers as an ordered queue of indices.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_mask_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        Load;
    logic [15:0] Mask;
    logic        Ack;
    logic        Ready;
    logic        Valid;
    logic [3:0]  RegId;
    logic [4:0]  Remaining;
    logic        Done;

    int tests = 0;
    int fails = 0;

    // Reference model: pending register indices in emission order.
    int q[$];
    bit m_done = 1'b0;

    reg_mask_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .Load      (Load),
        .Mask      (Mask),
        .Ack       (Ack),
        .Ready     (Ready),
        .Valid     (Valid),
        .RegId     (RegId),
        .Remaining (Remaining),
        .Done      (Done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_update(input bit r, input bit ld, input logic [15:0] m, input bit ak);
        logic [15:0] eff;
        bit nd;
        nd = 1'b0;
        if (r) begin
            q.delete();
        end else if (q.size() == 0) begin
            if (ld) begin
                eff = m;
`ifdef MASK_ENC_SKIP_R0_EN
                eff[0] = 1'b0;
`endif
                if (eff == 16'd0) nd = 1'b1;
                else for (int i = 0; i < 16; i++) if (eff[i]) q.push_back(i);
            end
        end else if (ak) begin
            void'(q.pop_front());
            if (q.size() == 0) nd = 1'b1;
        end
        m_done = nd;
    endtask

    task automatic check_all();
        logic [15:0] exp_id;
        exp_id = (q.size() > 0) ? 16'(q[0]) : 16'd0;
        check("valid",     16'(Valid),     16'(q.size() > 0));
        check("ready",     16'(Ready),     16'(q.size() == 0));
        check("regid",     16'(RegId),     exp_id);
        check("remaining", 16'(Remaining), 16'(q.size()));
        check("done",      16'(Done),      16'(m_done));
    endtask

    // One clock: drive inputs, advance model with the same inputs, compare.
    task automatic step(input bit r, input bit ld, input logic [15:0] m, input bit ak);
        rst = r; Load = ld; Mask = m; Ack = ak;
        @(posedge clk);
        model_update(r, ld, m, ak);
        #1;
        check_all();
    endtask

    initial begin
        logic [15:0] rm;
        rst = 1'b1; Load = 1'b0; Mask = 16'd0; Ack = 1'b0;

        // Reset, with Load/Ack asserted to show reset priority.
        step(1, 0, 16'h0000, 0);
        step(1, 1, 16'hFFFF, 1);
        check("rst_remaining", 16'(Remaining), 16'd0);

        // 8421 with Ack held high: 0,5,10,15 then Done.
        step(0, 1, 16'h8421, 1);
        check("8421_first_id", 16'(RegId), 16'd0);
        check("8421_first_rem", 16'(Remaining), 16'd4);
        repeat (4) step(0, 0, 16'h0000, 1);
        check("8421_done", 16'(Done), 16'd1);
        step(0, 0, 16'h0000, 0);

        // Empty mask: Done next cycle, never Valid.
        step(0, 1, 16'h0000, 0);
        check("zero_done", 16'(Done), 16'd1);
        step(0, 0, 16'h0000, 0);

        // Stall with Ack low, then drain.
        step(0, 1, 16'h0003, 0);
        repeat (5) step(0, 0, 16'h0000, 0);
        repeat (3) step(0, 0, 16'h0000, 1);

        // Load during EMIT ignored.
        step(0, 1, 16'h00F0, 0);
        step(0, 1, 16'hFFFF, 1);
        step(0, 1, 16'hFFFF, 1);
        repeat (4) step(0, 0, 16'h0000, 1);

        // Reset mid-drain: no Done afterwards.
        step(0, 1, 16'hFFFF, 0);
        repeat (3) step(0, 0, 16'h0000, 1);
        step(1, 0, 16'h0000, 1);
        step(0, 0, 16'h0000, 1);
        check("rst_mid_no_done", 16'(Done), 16'd0);

        // Ack in IDLE ignored; bit 0 behaviour depends on configuration.
        step(0, 0, 16'h0000, 1);
        step(0, 1, 16'h0001, 0);
        step(0, 0, 16'h0000, 1);
        step(0, 0, 16'h0000, 0);
        step(0, 1, 16'h0003, 0);
`ifdef MASK_ENC_SKIP_R0_EN
        check("skip_r0_id", 16'(RegId), 16'd1);
        check("skip_r0_rem", 16'(Remaining), 16'd1);
`else
        check("r0_id", 16'(RegId), 16'd0);
        check("r0_rem", 16'(Remaining), 16'd2);
`endif
        repeat (3) step(0, 0, 16'h0000, 1);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 4))
                0: rm = 16'd0;
                1: rm = 16'd1 << $urandom_range(0, 15);
                2: rm = 16'hFFFF;
                default: rm = 16'($urandom);
            endcase
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) == 0), rm,
                 ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_mask_encoder.md
REG_MASK_ENCODER -- requirements
Module: reg_mask_encoder

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset sampled on rising clk.
REQ-003 SHALL have port Load, input, 1, request to capture Mask; honored only while Ready=1.
REQ-004 SHALL have port Mask, input, 16, register-select vector with bit i selecting register i.
REQ-005 SHALL have port Ack, input, 1, consumer accepts the current RegId; honored only while Valid=1.
REQ-006 SHALL have port Ready, output, 1, high when IDLE and able to accept Load.
REQ-007 SHALL have port Valid, output, 1, high when RegId holds a pending register index.
REQ-008 SHALL have port RegId, output, 4, index of the lowest set bit of the pending mask.
REQ-009 SHALL have port Remaining, output, 5, population count of the pending mask, range 0..16.
REQ-010 SHALL have port Done, output, 1, single-cycle pulse when a loaded mask is fully drained.

Function
REQ-011 SHALL implement two states: IDLE and EMIT, with a 16-bit pending-mask register.
REQ-012 In IDLE: Ready=1, Valid=0, and RegId=0.
REQ-013 In IDLE with Load=1 and a nonzero effective mask: capture it and enter EMIT next cycle, with Valid=1 in that cycle (1-cycle latency).
REQ-014 In IDLE with Load=1 and an all-zero effective mask: stay in IDLE and pulse Done=1 in the next cycle.
REQ-015 In EMIT: RegId = lowest set bit index of the pending mask, and it is combinational from the registered mask.
REQ-016 In EMIT with Ack=1: clear bit RegId in the next cycle, and decrement Remaining by 1.
REQ-017 In EMIT with Ack=1 and Remaining=1: go to IDLE and pulse Done=1 in the next cycle.
REQ-018 In EMIT with Ack=0: hold the mask, RegId, and Remaining stable indefinitely.
REQ-019 Load asserted during EMIT SHALL be ignored, and the pending mask is unaffected.
REQ-020 Ack asserted during IDLE SHALL be ignored.
REQ-021 Decoding RegId 4-to-16 SHALL yield a one-hot word whose single bit is set in the pending mask whenever Valid=1.
REQ-022 Throughput: one index per cycle with Ack held high, so a full mask of 16 bits drains in 16 Ack cycles.
REQ-023 Done SHALL be high for exactly one cycle per accepted Load and SHALL never be high alongside Valid.

Reset
REQ-024 With rst=1, on the next edge the block SHALL enter IDLE, pending mask=0, Remaining=0, Done=0, Valid=0, RegId=0, and Ready=1.
REQ-025 Reset mid-EMIT SHALL discard the pending mask without a Done pulse.
REQ-026 Reset SHALL take priority over simultaneous Load/Ack.

Configuration
REQ-027 With macro MASK_ENC_SKIP_R0_EN defined, the effective mask SHALL be Mask with bit 0 forced to 0, so R0 is never emitted and is excluded from Remaining.
REQ-028 Without MASK_ENC_SKIP_R0_EN, the effective mask SHALL equal Mask, and RegId=0 is emitted when bit 0 is set.

Verification
REQ-029 Load Mask=16'h8421, Ack held high -> RegId sequence 0,5,10,15 on consecutive cycles, Remaining 4,3,2,1, then Done pulse and Ready=1.
REQ-030 Load Mask=16'h0000 -> no Valid, Done=1 for one cycle in the next cycle, and Ready stays 1.
REQ-031 Load 16'h0003, Ack low 5 cycles then high -> RegId=0 stable with Remaining=2 during the stall, then 1, then Done.
REQ-032 Load 16'h00F0, then Load 16'hFFFF during EMIT -> only indices 4,5,6,7 are emitted and the second Load is ignored.
REQ-033 Load 16'hFFFF, assert rst after 3 Acks -> next cycle IDLE, Remaining=0, and no Done pulse.
REQ-034 With MASK_ENC_SKIP_R0_EN defined, Load 16'h0001 -> immediate Done, no Valid; Load 16'h0003 -> single RegId=1 with Remaining=1.
